// File: rtl/midi_decoder.sv
// MIDI note-message decoder: turns a MIDI byte stream into note on/off events.
// Latency: event_valid pulses the cycle after the edge that samples the final data byte.
// Backpressure: none; bytes are consumed whenever byte_valid=1 and events are one-cycle pulses.
// Ports: clk/reset (async, active-high); byte_valid/byte_in from the UART receiver;
//        event_valid/note_en/note/velocity toward the polyphony stage.

package midi_decoder_pkg;
  typedef enum logic {
    NOTE_OFF = 1'b0,
    NOTE_ON  = 1'b1
  } note_en_t;
endpackage

module midi_decoder
  import midi_decoder_pkg::*;
#(
  parameter int CHANNEL = 0,
  parameter bit OMNI    = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       byte_valid,
  input  logic [7:0] byte_in,
  output logic       event_valid,
  output note_en_t   note_en,
  output logic [6:0] note,
  output logic [6:0] velocity
);

  typedef enum logic [2:0] {
    NO_STATUS,
    NOTE_D1,
    NOTE_D2,
    SKIP_D1,
    SKIP_D2,
    SKIP_1B
  } state_t;

  localparam logic [3:0] CH = 4'(CHANNEL);

  state_t     state_q, state_d;
  logic       run_on_q, run_on_d;       // running status kind: 1 = note-on, 0 = note-off
  logic [6:0] note_buf_q, note_buf_d;   // first data byte, held until the velocity arrives
  logic       event_valid_q, event_valid_d;
  note_en_t   note_en_q, note_en_d;
  logic [6:0] note_q, note_d;
  logic [6:0] velocity_q, velocity_d;

  logic is_status;
  logic is_realtime;
  logic ch_match;

  assign is_status   = byte_in[7];
  assign is_realtime = (byte_in[7:3] == 5'b11111);   // 0xF8..0xFF
  assign ch_match    = OMNI || (byte_in[3:0] == CH);

  always_comb begin
    state_d       = state_q;
    run_on_d      = run_on_q;
    note_buf_d    = note_buf_q;
    event_valid_d = 1'b0;
    note_en_d     = note_en_q;
    note_d        = note_q;
    velocity_d    = velocity_q;

    if (byte_valid) begin
      if (is_status) begin
        // Real-time bytes may interleave anywhere and must leave the parser untouched.
        if (!is_realtime) begin
          case (byte_in[7:4])
            4'h8, 4'h9: begin
              if (ch_match) begin
                state_d  = NOTE_D1;
                run_on_d = byte_in[4];
              end else begin
                state_d = SKIP_D1;
              end
            end
            4'hA, 4'hB, 4'hE: state_d = SKIP_D1;
            4'hC, 4'hD:       state_d = SKIP_1B;
            default: begin
              // 0xF0..0xF7: system common / sysex cancels running status.
              state_d  = NO_STATUS;
              run_on_d = 1'b0;
            end
          endcase
        end
      end else begin
        case (state_q)
          NOTE_D1: begin
            note_buf_d = byte_in[6:0];
            state_d    = NOTE_D2;
          end
          NOTE_D2: begin
            note_d        = note_buf_q;
            velocity_d    = byte_in[6:0];
            // Note-on with zero velocity is a note-off by MIDI convention.
            note_en_d     = (run_on_q && (byte_in[6:0] != 7'd0)) ? NOTE_ON : NOTE_OFF;
            event_valid_d = 1'b1;
            state_d       = NOTE_D1;
          end
          SKIP_D1: state_d = SKIP_D2;
          SKIP_D2: state_d = SKIP_D1;
          default: state_d = state_q;   // NO_STATUS discards, SKIP_1B stays
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= NO_STATUS;
      run_on_q      <= 1'b0;
      note_buf_q    <= 7'd0;
      event_valid_q <= 1'b0;
      note_en_q     <= NOTE_OFF;
      note_q        <= 7'd0;
      velocity_q    <= 7'd0;
    end else begin
      state_q       <= state_d;
      run_on_q      <= run_on_d;
      note_buf_q    <= note_buf_d;
      event_valid_q <= event_valid_d;
      note_en_q     <= note_en_d;
      note_q        <= note_d;
      velocity_q    <= velocity_d;
    end
  end

  assign event_valid = event_valid_q;
  assign note_en     = note_en_q;
  assign note        = note_q;
  assign velocity    = velocity_q;

endmodule

// File: tb/tb_midi_decoder.sv
// Bench for midi_decoder: one channel-0 instance and one OMNI instance share the byte stream.
// Expected events are queued when stimulus is issued; a negedge monitor pops and compares.
module tb_midi_decoder;
  import midi_decoder_pkg::*;

  logic       clk;
  logic       reset;
  logic       byte_valid;
  logic [7:0] byte_in;

  logic       ev0, ev1;
  note_en_t   ne0, ne1;
  logic [6:0] n0, n1, v0, v1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       en;
    logic [6:0] note;
    logic [6:0] vel;
  } ev_t;

  ev_t q0[$];
  ev_t q1[$];
  ev_t last0, last1;

  midi_decoder #(.CHANNEL(0), .OMNI(1'b0)) dut0 (
    .clk(clk), .reset(reset), .byte_valid(byte_valid), .byte_in(byte_in),
    .event_valid(ev0), .note_en(ne0), .note(n0), .velocity(v0)
  );

  midi_decoder #(.CHANNEL(0), .OMNI(1'b1)) dut1 (
    .clk(clk), .reset(reset), .byte_valid(byte_valid), .byte_in(byte_in),
    .event_valid(ev1), .note_en(ne1), .note(n1), .velocity(v1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard monitor ----------------
  task automatic pop_cmp(input int id, input logic en, input logic [6:0] n, input logic [6:0] v);
    ev_t e;
    int  sz;
    sz = (id == 0) ? q0.size() : q1.size();
    checks++;
    if (sz == 0) begin
      errors++;
      $display("FAIL unexpected_event dut%0d: got en=%0d note=%h vel=%h, required no event",
               id, en, n, v);
    end else begin
      if (id == 0) e = q0.pop_front();
      else         e = q1.pop_front();
      if (e.en !== en || e.note !== n || e.vel !== v) begin
        errors++;
        $display("FAIL event_fields dut%0d: got en=%0d note=%h vel=%h, required en=%0d note=%h vel=%h",
                 id, en, n, v, e.en, e.note, e.vel);
      end
    end
  endtask

  logic p0 = 1'b0;
  logic p1 = 1'b0;
  always @(negedge clk) begin
    if (ev0 === 1'b1) begin
      checks++;
      if (p0) begin
        errors++;
        $display("FAIL pulse_width dut0: event_valid high two cycles, required one");
      end
      pop_cmp(0, ne0, n0, v0);
    end
    if (ev1 === 1'b1) begin
      checks++;
      if (p1) begin
        errors++;
        $display("FAIL pulse_width dut1: event_valid high two cycles, required one");
      end
      pop_cmp(1, ne1, n1, v1);
    end
    p0 = (ev0 === 1'b1);
    p1 = (ev1 === 1'b1);
  end

  // ---------------- stimulus helpers ----------------
  task automatic expect_ev(input bit m0, input bit m1, input logic en,
                           input logic [6:0] n, input logic [6:0] v);
    ev_t e;
    e.en = en; e.note = n; e.vel = v;
    if (m0) begin q0.push_back(e); last0 = e; end
    if (m1) begin q1.push_back(e); last1 = e; end
  endtask

  // One byte, then one idle cycle with random junk on byte_in that must be ignored.
  task automatic send(input logic [7:0] b);
    byte_in    = b;
    byte_valid = 1'b1;
    @(posedge clk); #1;
    byte_valid = 1'b0;
    byte_in    = 8'($urandom);
    @(posedge clk); #1;
  endtask

  task automatic check_hold(input string tag);
    checks++;
    if (ne0 !== note_en_t'(last0.en) || n0 !== last0.note || v0 !== last0.vel || ev0 !== 1'b0) begin
      errors++;
      $display("FAIL hold_%s dut0: got ev=%0d en=%0d note=%h vel=%h, required ev=0 en=%0d note=%h vel=%h",
               tag, ev0, ne0, n0, v0, last0.en, last0.note, last0.vel);
    end
    checks++;
    if (ne1 !== note_en_t'(last1.en) || n1 !== last1.note || v1 !== last1.vel || ev1 !== 1'b0) begin
      errors++;
      $display("FAIL hold_%s dut1: got ev=%0d en=%0d note=%h vel=%h, required ev=0 en=%0d note=%h vel=%h",
               tag, ev1, ne1, n1, v1, last1.en, last1.note, last1.vel);
    end
  endtask

  task automatic clear_last();
    last0.en = 1'b0; last0.note = 7'd0; last0.vel = 7'd0;
    last1 = last0;
  endtask

  // ---------------- directed sequences ----------------
  initial begin
    byte_valid = 1'b0;
    byte_in    = 8'h00;
    reset      = 1'b1;
    clear_last();
    repeat (2) @(posedge clk);
    #1;
    check_hold("reset_active");
    reset = 1'b0;
    @(posedge clk); #1;
    check_hold("reset_release");

    // Data bytes with no status must be discarded.
    send(8'h3C); send(8'h64);
    check_hold("no_status");

    // Basic note-on.
    expect_ev(1, 1, 1'b1, 7'h3C, 7'h64);
    send(8'h90); send(8'h3C); send(8'h64);
    check_hold("note_on");

    // Running status, second message is note-on with velocity 0 -> off.
    expect_ev(1, 1, 1'b1, 7'h3C, 7'h64);
    expect_ev(1, 1, 1'b0, 7'h40, 7'h00);
    send(8'h90); send(8'h3C); send(8'h64); send(8'h40); send(8'h00);
    check_hold("running_status");

    // Real-time byte inside a message is transparent.
    expect_ev(1, 1, 1'b1, 7'h3C, 7'h64);
    send(8'h90); send(8'h3C); send(8'hF8); send(8'h64);
    check_hold("realtime_mid");

    // Channel 1 note: only the OMNI instance reacts.
    expect_ev(0, 1, 1'b1, 7'h3C, 7'h64);
    send(8'h91); send(8'h3C); send(8'h64);
    check_hold("channel_filter");

    // Control change skipped in pairs, then a note-off.
    expect_ev(1, 1, 1'b0, 7'h3C, 7'h10);
    send(8'hB0); send(8'h07); send(8'h7F); send(8'h3C); send(8'h64);
    send(8'h80); send(8'h3C); send(8'h10);
    check_hold("cc_then_off");

    // Note-off status with full velocity is still OFF.
    expect_ev(1, 1, 1'b0, 7'h11, 7'h7F);
    send(8'h80); send(8'h11); send(8'h7F);
    check_hold("off_high_vel");

    // Program change (single data byte) and sysex produce nothing.
    send(8'hC0); send(8'h05); send(8'h3C); send(8'h64);
    send(8'hF0); send(8'h3C); send(8'h64); send(8'hF7);
    check_hold("skip_1b_sysex");

    // Real-time bytes inside a skipped CC must not disturb pair counting.
    send(8'hB0); send(8'hF8); send(8'h07); send(8'hFE); send(8'h7F); send(8'h3C); send(8'h64);
    check_hold("cc_realtime");

    // New status aborts a partial message.
    expect_ev(1, 1, 1'b1, 7'h40, 7'h50);
    send(8'h90); send(8'h3C); send(8'h90); send(8'h40); send(8'h50);
    check_hold("abort_partial");

    // Channel 15 note-on: only OMNI accepts.
    expect_ev(0, 1, 1'b1, 7'h22, 7'h33);
    send(8'h9F); send(8'h22); send(8'h33);
    check_hold("channel15");

    // Reset mid-message: outputs cleared asynchronously, trailing data ignored.
    send(8'h90); send(8'h3C);
    #2 reset = 1'b1;
    #1;
    clear_last();
    check_hold("async_reset");
    @(posedge clk); #1;
    reset = 1'b0;
    send(8'h64); check_hold("post_reset_a");
    send(8'h3C); check_hold("post_reset_b");
    send(8'h64); check_hold("post_reset_c");

    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (q0.size() != 0) begin
      errors++;
      $display("FAIL missing_events dut0: got %0d outstanding, required 0", q0.size());
    end
    checks++;
    if (q1.size() != 0) begin
      errors++;
      $display("FAIL missing_events dut1: got %0d outstanding, required 0", q1.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
